// File: rtl/time_display_pkg.sv
// Shared types and constants for the multiplexed time display.
package time_display_pkg;

  localparam int NUM_DIGITS = 6;

  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg_t;

  // Segment patterns are active-low {g,f,e,d,c,b,a}
  localparam seg_t SEG_BLANK = 7'h7F;
  localparam seg_t SEG_DASH  = 7'h3F;

endpackage

// File: rtl/seg7_encode.sv
// Combinational BCD to active-low 7-segment decoder; non-decimal codes show a dash.
module seg7_encode
  import time_display_pkg::*;
(
  input  bcd_t bcd,
  output seg_t seg
);

  // Map each decimal digit to its segment pattern; anything above 9 is a dash
  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/time_display_scan.sv
// Six-digit hh:mm:ss scanner for a common-anode display. Captures one snapshot
// per frame, blanks a guard interval at the start of every digit slot, flags
// invalid digits with a dash and blinks the colon from the seconds LSB.
// Optional build macro LZ_BLANK_EN blanks a leading zero on the hours-tens digit.
module time_display_scan
  import time_display_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int GUARD_CYCLES = 16
)
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] hr_high_bcd,
  input  logic [3:0] hr_low_bcd,
  input  logic [2:0] min_high_bcd,
  input  logic [3:0] min_low_bcd,
  input  logic [2:0] sec_high_bcd,
  input  logic [3:0] sec_low_bcd,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] dig_en,
  output logic       frame_start
);

  localparam int               CNT_W     = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_END = CNT_W'(GUARD_CYCLES);
  localparam logic [2:0]       IDX_LAST  = 3'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] slot_cnt;
  logic [2:0]       idx;
  bcd_t             snapshot [NUM_DIGITS];

  logic             slot_last;
  logic             frame_last;
  logic             in_guard;
  bcd_t             cur_digit;
  seg_t             dec_seg;
  seg_t             seg_next;
  logic             dp_next;
  logic [5:0]       dig_en_next;

  assign slot_last  = (slot_cnt == SLOT_LAST);
  assign frame_last = slot_last && (idx == IDX_LAST);
  assign in_guard   = (slot_cnt < GUARD_END);

  // Slot timer and digit index; the index advances each time the slot timer wraps
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_cnt <= '0;
      idx      <= '0;
    end else if (slot_last) begin
      slot_cnt <= '0;
      idx      <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  // Capture all six digits together on the last cycle of a frame so a frame never tears
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) snapshot[i] <= '0;
    end else if (frame_last) begin
      snapshot[0] <= {2'b00, hr_high_bcd};
      snapshot[1] <= hr_low_bcd;
      snapshot[2] <= {1'b0, min_high_bcd};
      snapshot[3] <= min_low_bcd;
      snapshot[4] <= {1'b0, sec_high_bcd};
      snapshot[5] <= sec_low_bcd;
    end
  end

  // Pick the snapshot digit belonging to the current slot
  always_comb begin
    cur_digit = '0;
    case (idx)
      3'd0:    cur_digit = snapshot[0];
      3'd1:    cur_digit = snapshot[1];
      3'd2:    cur_digit = snapshot[2];
      3'd3:    cur_digit = snapshot[3];
      3'd4:    cur_digit = snapshot[4];
      3'd5:    cur_digit = snapshot[5];
      default: cur_digit = '0;
    endcase
  end

  seg7_encode u_encode (
    .bcd (cur_digit),
    .seg (dec_seg)
  );

  // Build the next output word: everything dark in the guard, one digit lit afterwards
  always_comb begin
    seg_next    = SEG_BLANK;
    dp_next     = 1'b1;
    dig_en_next = 6'h3F;
    if (!in_guard) begin
      dig_en_next = ~(6'b000001 << idx);
      seg_next    = dec_seg;
`ifdef LZ_BLANK_EN
      if (idx == 3'd0 && cur_digit == 4'd0) seg_next = SEG_BLANK;
`else
`endif
      if ((idx == 3'd1 || idx == 3'd3) && !snapshot[5][0]) dp_next = 1'b0;
    end
  end

  // Register every pin so the display sees clean, glitch-free transitions
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg         <= SEG_BLANK;
      dp          <= 1'b1;
      dig_en      <= 6'h3F;
      frame_start <= 1'b0;
    end else begin
      seg         <= seg_next;
      dp          <= dp_next;
      dig_en      <= dig_en_next;
      frame_start <= (idx == 3'd0) && (slot_cnt == '0);
    end
  end

endmodule
